// File: rtl/multi_io_deglitch_if.sv
// multi_io_deglitch_if
//   Groups the per-channel data and control signals of multi_io_deglitch.
//   Signals:
//     in          raw asynchronous channel inputs        (master -> slave)
//     bypass      per-channel filter bypass               (master -> slave)
//     glitch_clr  synchronous clear of glitch_cnt         (master -> slave)
//     out         filtered channel levels                 (slave -> master)
//     rise        1-cycle pulse when out[i] goes 0->1     (slave -> master)
//     fall        1-cycle pulse when out[i] goes 1->0     (slave -> master)
//     glitch_cnt  saturating glitch-reject cycle count    (slave -> master)
interface multi_io_deglitch_if #(
  parameter int unsigned NUM_CH = 4
) ();

  logic [NUM_CH-1:0] in;
  logic [NUM_CH-1:0] bypass;
  logic              glitch_clr;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [7:0]        glitch_cnt;

  modport master (
    output in,
    output bypass,
    output glitch_clr,
    input  out,
    input  rise,
    input  fall,
    input  glitch_cnt
  );

  modport slave (
    input  in,
    input  bypass,
    input  glitch_clr,
    output out,
    output rise,
    output fall,
    output glitch_cnt
  );

endinterface

// File: rtl/multi_io_deglitch.sv
// multi_io_deglitch
//   N-channel debounce/deglitch filter for slow board-level control inputs.
//   Each channel: 2-flop synchroniser, then a per-channel stability counter. The filtered
//   output only takes a new level once that level has been seen on the synchroniser output
//   for RISE_CNT (0->1) or FALL_CNT (1->0) consecutive cycles. Any break restarts the count.
//   Ports:
//     clk  single clock domain
//     rst  asynchronous, active-high reset
//     bus  multi_io_deglitch_if.slave: in, bypass, glitch_clr -> out, rise, fall, glitch_cnt
module multi_io_deglitch #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       RISE_CNT  = 350,
  parameter int unsigned       FALL_CNT  = 350,
  parameter int unsigned       CNT_WIDTH = 10,
  parameter logic [NUM_CH-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  multi_io_deglitch_if.slave  bus
);

  localparam int unsigned MaxThr = (RISE_CNT > FALL_CNT) ? RISE_CNT : FALL_CNT;

  // The counter must be able to hold threshold-1 without wrapping.
  if (NUM_CH < 1 || RISE_CNT < 1 || FALL_CNT < 1 || CNT_WIDTH < 1 ||
      CNT_WIDTH > 31 || (MaxThr - 1) >= (32'd1 << CNT_WIDTH)) begin : g_param_err
    $error("multi_io_deglitch: invalid NUM_CH/RISE_CNT/FALL_CNT/CNT_WIDTH combination");
  end

  localparam logic [CNT_WIDTH-1:0] RiseLast = CNT_WIDTH'(RISE_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] FallLast = CNT_WIDTH'(FALL_CNT - 1);

  logic [NUM_CH-1:0]    s1_q, s2_q;
  logic [NUM_CH-1:0]    out_q, out_d;
  logic [NUM_CH-1:0]    rise_q, rise_d;
  logic [NUM_CH-1:0]    fall_q, fall_d;
  logic [NUM_CH-1:0]    reject;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [7:0]           glitch_q, glitch_d;

  // Synchroniser; s1 is the only flop that sees the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= bus.in;
      s2_q <= s1_q;
    end
  end

  // Per-channel filter next state.
  always_comb begin
    out_d  = out_q;
    reject = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.bypass[i]) begin
        // Pending count is discarded silently; not a glitch.
        out_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else if (s2_q[i] != out_q[i]) begin
        // While mismatched, s2 is the candidate level, so it selects the threshold.
        if (cnt_q[i] == (s2_q[i] ? RiseLast : FallLast)) begin
          out_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (cnt_q[i] != '0) begin
        cnt_d[i]  = '0;
        reject[i] = 1'b1;
      end
    end
    // Pulses registered together with the output update.
    rise_d = out_d & ~out_q;
    fall_d = ~out_d & out_q;
  end

  // One increment per cycle however many channels reject; clear wins.
  always_comb begin
    glitch_d = glitch_q;
    if (bus.glitch_clr) begin
      glitch_d = '0;
    end else if (|reject && glitch_q != 8'hFF) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      glitch_q <= '0;
    end else begin
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.glitch_cnt = glitch_q;

endmodule
